instr_queue_sched: RTL and testbench
====================================

Name: instr_queue_sched

Overview:
- Controller for the front-end instruction queue: sequences enqueue, dequeue and flush for the queue.
- Accepts uop groups from decode and decides each cycle the safe enq/deq counts, so the queue never overflows or underflows.
- Throttles dispatch against downstream reservation-station credits.
- Runs the flush/recovery sequence on a redirect.

Parameters:
- Q_DEPTH, uop_pkg::INSTR_Q_DEPTH: queue entries; the scheduler keeps its own shadow occupancy.
- Q_WIDTH, uop_pkg::INSTR_Q_WIDTH: max uops enqueued or dequeued per cycle.
- CREDITS, 16: downstream dispatch slots available after reset.
- RECOVER_CYCLES, 2: cycles that enq/deq stay blocked after the flush cycle; minimum 1.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous, active-high reset.
- redirect_in  input  1  mispredict/exception redirect; requests a flush.
- fe_valid_in  input  1  decode offers a uop group.
- fe_count_in  input  CW=$clog2(Q_WIDTH+1)  uops offered (1..Q_WIDTH when valid).
- fe_ready_out  output  1  group accepted this cycle, all-or-nothing.
- credit_ret_in  input  CW  downstream slots freed this cycle.
- q_enq_out  output  CW  drives the queue's enq count.
- q_deq_out  output  CW  drives the queue's deq count; also the dispatch count to rename.
- q_flush_out  output  1  drives the queue's flush.
- occ_out  output  $clog2(Q_DEPTH+1)  shadow occupancy.
- credits_out  output  $clog2(CREDITS+1)  current credits.
- state_out  output  2  0=RUN, 1=FLUSH, 2=RECOVER.
- stall_cnt_out  output  32  see Optional Feature.

Behaviour:
- Reset (rst_in high at a clock edge; dominates all other inputs):
  - state=RUN, occ=0, credits=CREDITS, recover counter=0, stall counter=0.
  - Outputs with fe_valid_in low: q_enq_out=0, q_deq_out=0, q_flush_out=0, fe_ready_out=0.
  - Reset mid-FLUSH/RECOVER returns directly to RUN.
- All outputs are combinational from registered state and the current inputs. Zero-cycle decision latency.
- RUN:
  - fe_ready_out = fe_valid_in && !redirect_in && fe_count_in <= Q_DEPTH-occ. Uses registered occ; same-cycle dequeue is not credited.
  - q_enq_out = fe_ready_out ? fe_count_in : 0.
  - q_deq_out = redirect_in ? 0 : min(occ, Q_WIDTH, credits).
- Next-state arithmetic, using widened intermediates with no truncation:
  - occ_next = occ + q_enq_out - q_deq_out.
  - credits_next = min(CREDITS, credits - q_deq_out + credit_ret_in).
  - credit_ret_in is accepted in every state.
- redirect_in high in RUN: no enq/deq that cycle; next state FLUSH.
- FLUSH (exactly one cycle):
  - q_flush_out=1, enq=deq=0, fe_ready_out=0.
  - occ_next=0, recover counter loaded with RECOVER_CYCLES.
  - Next state RECOVER.
- RECOVER:
  - enq=deq=0, fe_ready_out=0, q_flush_out=0.
  - Counter decrements each cycle; at 1 goes to RUN.
- redirect_in in FLUSH or RECOVER: next state FLUSH, so the sequence restarts.
- Credits are not modified by flush.
- Boundaries:
  - occ==Q_DEPTH: no enq.
  - occ==0 or credits==0: q_deq_out=0.
  - fe_count_in exactly equal to free space is accepted.
  - Credit overflow clamps at CREDITS.
- state_out==3 is unreachable; it decodes as RUN-safe: enq=deq=0, next state RUN.

Optional Feature:
- Macro: INSTR_Q_SCHED_STALL_CNT_EN.
- Defined: stall_cnt_out is a 32-bit saturating counter. It increments each cycle in RUN with occ>0 and credits==0. It is cleared by reset only.
- Undefined: stall_cnt_out is tied to 0 and no counter logic exists.

Test Plan:
- Reset, then fe_valid=1, fe_count=4, Q_WIDTH=4, CREDITS=16 -> cycle 0: fe_ready=1, q_enq=4, q_deq=0. Cycle 1: occ=4, q_deq=4.
- Fill to occ=30 with Q_DEPTH=32 and zero credits; offer 3 -> fe_ready=0, q_enq=0. Offer 2 -> accepted, occ=32, and further offers are rejected.
- credits=2, occ=10 -> q_deq=2, credits→0, q_deq=0. Then credit_ret=3 -> next cycle q_deq=3. credit_ret pushing past 16 -> credits_out stays 16.
- occ=8, redirect_in pulse with fe_valid=1 -> that cycle enq=deq=0. Next: state FLUSH, q_flush=1. Then RECOVER for 2 cycles with fe_ready=0. Then RUN, occ=0.
- redirect during RECOVER cycle 1 -> FLUSH again, full 2-cycle RECOVER repeats. rst_in during RECOVER -> RUN next cycle, credits=16.
- With INSTR_Q_SCHED_STALL_CNT_EN: occ=5, credits=0 for 7 cycles -> stall_cnt_out=7. Without the macro -> stall_cnt_out stays 0.

Source files
------------

// File: rtl/instr_queue_sched.sv
// instr_queue_sched -- front-end instruction queue controller.
//
// Purpose:
//   Decides each cycle how many uops the instruction queue may accept from
//   decode and how many it may dispatch to rename. It keeps a shadow
//   occupancy so the queue never overflows or underflows. Dispatch is
//   throttled by downstream reservation-station credits. On a redirect the
//   controller runs a one-cycle FLUSH followed by RECOVER_CYCLES cycles of
//   RECOVER, during which enq and deq are blocked.
//
// Ports:
//   clk_in         clock
//   rst_in         synchronous, active-high reset
//   redirect_in    mispredict/exception redirect (requests a flush)
//   fe_valid_in    decode offers a uop group
//   fe_count_in    number of uops offered (1..Q_WIDTH when valid)
//   fe_ready_out   group accepted this cycle (all-or-nothing)
//   credit_ret_in  downstream slots freed this cycle
//   q_enq_out      queue enqueue count
//   q_deq_out      queue dequeue count / dispatch count to rename
//   q_flush_out    queue flush
//   occ_out        shadow occupancy
//   credits_out    current dispatch credits
//   state_out      0=RUN, 1=FLUSH, 2=RECOVER
//   stall_cnt_out  credit-stall cycle counter (zero unless enabled)
//
// Optional feature macro: INSTR_Q_SCHED_STALL_CNT_EN
//   Defined   : stall_cnt_out is a 32-bit saturating count of RUN cycles with
//               a non-empty queue and no credits.
//   Undefined : stall_cnt_out is tied to zero.

package uop_pkg;
  localparam int INSTR_Q_DEPTH = 32;
  localparam int INSTR_Q_WIDTH = 4;
endpackage

module instr_queue_sched #(
  parameter int Q_DEPTH        = uop_pkg::INSTR_Q_DEPTH,
  parameter int Q_WIDTH        = uop_pkg::INSTR_Q_WIDTH,
  parameter int CREDITS        = 16,
  parameter int RECOVER_CYCLES = 2,
  localparam int CW = $clog2(Q_WIDTH + 1),
  localparam int OW = $clog2(Q_DEPTH + 1),
  localparam int KW = $clog2(CREDITS + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          redirect_in,
  input  logic          fe_valid_in,
  input  logic [CW-1:0] fe_count_in,
  output logic          fe_ready_out,
  input  logic [CW-1:0] credit_ret_in,
  output logic [CW-1:0] q_enq_out,
  output logic [CW-1:0] q_deq_out,
  output logic          q_flush_out,
  output logic [OW-1:0] occ_out,
  output logic [KW-1:0] credits_out,
  output logic [1:0]    state_out,
  output logic [31:0]   stall_cnt_out
);

  localparam int RW = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] occ_reg, occ_next;
  logic [KW-1:0] credits_reg, credits_next;
  logic [RW-1:0] rcnt_reg, rcnt_next;

  // Wide intermediates so no arithmetic step can wrap.
  logic [31:0] free_space;
  logic [31:0] deq_avail;
  logic [31:0] occ_sum;
  logic [31:0] cred_sum;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= ST_RUN;
      occ_reg     <= '0;
      credits_reg <= KW'(CREDITS);
      rcnt_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      occ_reg     <= occ_next;
      credits_reg <= credits_next;
      rcnt_reg    <= rcnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rcnt_next    = rcnt_reg;
    fe_ready_out = 1'b0;
    q_enq_out    = '0;
    q_deq_out    = '0;
    q_flush_out  = 1'b0;

    // Free space uses registered occupancy only: a same-cycle dequeue does
    // not make room for a same-cycle enqueue.
    free_space = 32'(Q_DEPTH) - 32'(occ_reg);

    // Dispatch limit = min(occupancy, width, credits).
    deq_avail = 32'(occ_reg);
    if (32'(Q_WIDTH) < deq_avail) deq_avail = 32'(Q_WIDTH);
    if (32'(credits_reg) < deq_avail) deq_avail = 32'(credits_reg);

    case (state_reg)
      ST_RUN: begin
        if (redirect_in) begin
          state_next = ST_FLUSH;
        end else begin
          fe_ready_out = fe_valid_in && (32'(fe_count_in) <= free_space);
          q_enq_out    = fe_ready_out ? fe_count_in : '0;
          q_deq_out    = deq_avail[CW-1:0];
        end
      end
      ST_FLUSH: begin
        q_flush_out = 1'b1;
        rcnt_next   = RW'(RECOVER_CYCLES);
        state_next  = redirect_in ? ST_FLUSH : ST_RECOVER;
      end
      ST_RECOVER: begin
        if (redirect_in) begin
          state_next = ST_FLUSH;
        end else begin
          if (rcnt_reg <= RW'(1)) state_next = ST_RUN;
          if (rcnt_reg != '0) rcnt_next = rcnt_reg - RW'(1);
        end
      end
      default: begin
        // Unreachable encoding: block traffic and fall back to RUN.
        state_next = ST_RUN;
      end
    endcase

    occ_sum  = 32'(occ_reg) + 32'(q_enq_out) - 32'(q_deq_out);
    occ_next = (state_reg == ST_FLUSH) ? '0 : occ_sum[OW-1:0];

    // Credit returns are accepted in every state; flush leaves credits alone.
    cred_sum     = 32'(credits_reg) - 32'(q_deq_out) + 32'(credit_ret_in);
    credits_next = (cred_sum > 32'(CREDITS)) ? KW'(CREDITS) : cred_sum[KW-1:0];
  end

  assign occ_out     = occ_reg;
  assign credits_out = credits_reg;
  assign state_out   = state_reg;

`ifdef INSTR_Q_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == ST_RUN && occ_reg != '0 && credits_reg == '0 &&
                 stall_cnt_reg != 32'hFFFF_FFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_reg;
`else
  assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_instr_queue_sched.sv
// tb_instr_queue_sched -- directed testbench for instr_queue_sched with
// default parameters (Q_DEPTH=32, Q_WIDTH=4, CREDITS=16, RECOVER_CYCLES=2).
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further time unit later, well away from the next edge.

module tb_instr_queue_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic        fe_valid = 1'b0;
  logic [2:0]  fe_count = 3'd0;
  logic        fe_ready;
  logic [2:0]  credit_ret = 3'd0;
  logic [2:0]  q_enq;
  logic [2:0]  q_deq;
  logic        q_flush;
  logic [5:0]  occ;
  logic [4:0]  credits;
  logic [1:0]  state;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

`ifdef INSTR_Q_SCHED_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd7;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  instr_queue_sched dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .redirect_in   (redirect),
    .fe_valid_in   (fe_valid),
    .fe_count_in   (fe_count),
    .fe_ready_out  (fe_ready),
    .credit_ret_in (credit_ret),
    .q_enq_out     (q_enq),
    .q_deq_out     (q_deq),
    .q_flush_out   (q_flush),
    .occ_out       (occ),
    .credits_out   (credits),
    .state_out     (state),
    .stall_cnt_out (stall_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge; inputs may be changed right after it returns.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    $display("cycle %0d: state=%0d occ=%0d credits=%0d stall=%0d", cycle, state, occ, credits, stall_cnt);
  endtask

  task automatic drive(input logic v, input logic [2:0] cnt, input logic rd, input logic [2:0] ret);
    fe_valid = v; fe_count = cnt; redirect = rd; credit_ret = ret;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (occ !== 6'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occ); end
    checks++; if (credits !== 5'd16) begin errors++; $display("FAIL reset_credits: got %0d want 16", credits); end
    checks++; if ({fe_ready, q_enq, q_deq, q_flush} !== 8'd0) begin errors++; $display("FAIL reset_outputs: got ready=%0d enq=%0d deq=%0d flush=%0d want all 0", fe_ready, q_enq, q_deq, q_flush); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_enq_deq();
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    checks++; if (fe_ready !== 1'b1 || q_enq !== 3'd4 || q_deq !== 3'd0) begin errors++; $display("FAIL first_enq: got ready=%0d enq=%0d deq=%0d want 1/4/0", fe_ready, q_enq, q_deq); end
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    checks++; if (occ !== 6'd4 || q_deq !== 3'd4) begin errors++; $display("FAIL first_deq: got occ=%0d deq=%0d want 4/4", occ, q_deq); end
    tick();
    checks++; if (occ !== 6'd0 || credits !== 5'd12) begin errors++; $display("FAIL after_deq: got occ=%0d credits=%0d want 0/12", occ, credits); end
    checks++; if (q_deq !== 3'd0) begin errors++; $display("FAIL empty_deq: got %0d want 0", q_deq); end
  endtask

  task automatic test_fill();
    do_reset();
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (occ !== 6'd4 || credits !== 5'd0) begin errors++; $display("FAIL drain_credits: got occ=%0d credits=%0d want 4/0", occ, credits); end
    checks++; if (q_deq !== 3'd0) begin errors++; $display("FAIL zero_credit_deq: got %0d want 0", q_deq); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (occ !== 6'd28) begin errors++; $display("FAIL fill_28: got %0d want 28", occ); end
    drive(1'b1, 3'd2, 1'b0, 3'd0);
    tick();
    checks++; if (occ !== 6'd30) begin errors++; $display("FAIL fill_30: got %0d want 30", occ); end
    drive(1'b1, 3'd3, 1'b0, 3'd0);
    checks++; if (fe_ready !== 1'b0 || q_enq !== 3'd0) begin errors++; $display("FAIL over_offer: got ready=%0d enq=%0d want 0/0", fe_ready, q_enq); end
    tick();
    checks++; if (occ !== 6'd30) begin errors++; $display("FAIL reject_hold: got %0d want 30", occ); end
    drive(1'b1, 3'd2, 1'b0, 3'd0);
    checks++; if (fe_ready !== 1'b1 || q_enq !== 3'd2) begin errors++; $display("FAIL exact_fit: got ready=%0d enq=%0d want 1/2", fe_ready, q_enq); end
    tick();
    checks++; if (occ !== 6'd32) begin errors++; $display("FAIL full: got %0d want 32", occ); end
    drive(1'b1, 3'd1, 1'b0, 3'd0);
    checks++; if (fe_ready !== 1'b0 || q_enq !== 3'd0) begin errors++; $display("FAIL full_reject: got ready=%0d enq=%0d want 0/0", fe_ready, q_enq); end
  endtask

  task automatic test_credits();
    // Starts at occ=32, credits=0.
    drive(1'b0, 3'd0, 1'b0, 3'd2);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    checks++; if (credits !== 5'd2 || q_deq !== 3'd2) begin errors++; $display("FAIL credit_limited: got credits=%0d deq=%0d want 2/2", credits, q_deq); end
    tick();
    checks++; if (credits !== 5'd0 || q_deq !== 3'd0 || occ !== 6'd30) begin errors++; $display("FAIL credits_out: got credits=%0d deq=%0d occ=%0d want 0/0/30", credits, q_deq, occ); end
    drive(1'b0, 3'd0, 1'b0, 3'd3);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    checks++; if (q_deq !== 3'd3) begin errors++; $display("FAIL credit_return: got deq=%0d want 3", q_deq); end
    tick();
    checks++; if (occ !== 6'd27 || credits !== 5'd0) begin errors++; $display("FAIL after_ret: got occ=%0d credits=%0d want 27/0", occ, credits); end
    drive(1'b0, 3'd0, 1'b0, 3'd7);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (credits !== 5'd16 || occ !== 6'd15) begin errors++; $display("FAIL credit_reach_max: got credits=%0d occ=%0d want 16/15", credits, occ); end
    tick();
    checks++; if (credits !== 5'd16 || occ !== 6'd11) begin errors++; $display("FAIL credit_clamp: got credits=%0d occ=%0d want 16/11", credits, occ); end
    drive(1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic test_flush();
    // Starts at occ=11, credits=16.
    drive(1'b1, 3'd4, 1'b1, 3'd0);
    checks++; if (fe_ready !== 1'b0 || q_enq !== 3'd0 || q_deq !== 3'd0) begin errors++; $display("FAIL redirect_block: got ready=%0d enq=%0d deq=%0d want 0/0/0", fe_ready, q_enq, q_deq); end
    tick();
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    checks++; if (state !== 2'd1 || q_flush !== 1'b1 || fe_ready !== 1'b0 || q_deq !== 3'd0) begin errors++; $display("FAIL flush_cycle: got state=%0d flush=%0d ready=%0d deq=%0d want 1/1/0/0", state, q_flush, fe_ready, q_deq); end
    tick();
    checks++; if (state !== 2'd2 || occ !== 6'd0 || fe_ready !== 1'b0 || q_flush !== 1'b0) begin errors++; $display("FAIL recover_1: got state=%0d occ=%0d ready=%0d flush=%0d want 2/0/0/0", state, occ, fe_ready, q_flush); end
    tick();
    checks++; if (state !== 2'd2 || fe_ready !== 1'b0 || q_enq !== 3'd0) begin errors++; $display("FAIL recover_2: got state=%0d ready=%0d enq=%0d want 2/0/0", state, fe_ready, q_enq); end
    tick();
    checks++; if (state !== 2'd0 || occ !== 6'd0 || fe_ready !== 1'b1 || credits !== 5'd16) begin errors++; $display("FAIL back_to_run: got state=%0d occ=%0d ready=%0d credits=%0d want 0/0/1/16", state, occ, fe_ready, credits); end
    drive(1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic test_reflush();
    drive(1'b0, 3'd0, 1'b1, 3'd0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 1'b1, 3'd0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL reflush_in_recover: got state=%0d want 2", state); end
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    checks++; if (state !== 2'd1 || q_flush !== 1'b1) begin errors++; $display("FAIL reflush: got state=%0d flush=%0d want 1/1", state, q_flush); end
    tick();
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL reflush_recover_2: got state=%0d want 2", state); end
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reflush_run: got state=%0d want 0", state); end
    // Consume 4 credits, then reset in the middle of RECOVER.
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    checks++; if (credits !== 5'd12 || occ !== 6'd0) begin errors++; $display("FAIL pre_reset_credits: got credits=%0d occ=%0d want 12/0", credits, occ); end
    drive(1'b0, 3'd0, 1'b1, 3'd0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || credits !== 5'd16) begin errors++; $display("FAIL reset_in_recover: got state=%0d credits=%0d want 0/16", state, credits); end
  endtask

  task automatic test_stall_cnt();
    do_reset();
    drive(1'b1, 3'd4, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL stall_before: got %0d want 0", stall_cnt); end
    drive(1'b1, 3'd1, 1'b0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (occ !== 6'd5 || credits !== 5'd0) begin errors++; $display("FAIL stall_setup: got occ=%0d credits=%0d want 5/0", occ, credits); end
    checks++; if (stall_cnt !== STALL_EXP) begin errors++; $display("FAIL stall_count: got %0d want %0d", stall_cnt, STALL_EXP); end
  endtask

  initial begin
    test_reset();
    test_enq_deq();
    test_fill();
    test_credits();
    test_flush();
    test_reflush();
    test_stall_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
